// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain driver: accepts bitstream words over valid/ready,
// shifts them MSB-first into the CCFF chain and stops after CHAIN_LEN bits.
module ccff_chain_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              parity,
  output logic [CNT_W-1:0]  bits_shifted,
  output logic              tail_marker
);

  localparam int unsigned    IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN   = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_q, par_d;
  logic              tail_q, tail_d;
  logic              cur_bit;
  logic [CNT_W-1:0]  cnt_inc;

  assign cur_bit = shreg_q[idx_q];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Handshake is open only while waiting for the next word.
  assign word_ready    = (state_q == S_FETCH);
  assign ccff_head     = head_q;
  assign config_enable = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign parity        = par_q;
  assign bits_shifted  = cnt_q;
  assign tail_marker   = tail_q;

  always_ff @(posedge prog_clock or posedge prog_reset) begin
    if (prog_reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= par_d;
      tail_q  <= tail_d;
    end
  end

  // Chain shifts only in SHIFT; every other state drives enable and head low.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    head_d  = 1'b0;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    par_d   = par_q;
    tail_d  = tail_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          par_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        busy_d = 1'b1;
        if (word_valid) begin
          shreg_d = word_in;
          idx_d   = TOP_IDX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        head_d = cur_bit;
        en_d   = 1'b1;
        par_d  = par_q ^ cur_bit;
        cnt_d  = cnt_inc;
        // Chain full wins over word boundary: leftover bits are dropped.
        if (cnt_inc == LEN) begin
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          state_d = S_FETCH;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        tail_d  = ccff_tail;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
